// File: rtl/pvr_plane_pkg.sv
// Shared types and widths for the plane-equation setup engine.
package pvr_plane_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL,
        ST_SUB,
        ST_DIV_X,
        ST_DIV_Y,
        ST_CONST,
        ST_OUT
    } state_t;

    localparam int SUB_W       = 48;  // cross-product differences
    localparam int PROD_W      = 64;  // full 32x32 signed product
    localparam int MAX_FRAC    = 16;
    localparam int MUL_STEPS   = 6;
    // Two constant-term products plus one cycle to drain the product register.
    localparam int CONST_STEPS = 3;

endpackage

// File: rtl/serial_sdiv.sv
// Restoring signed divider, one quotient bit per cycle on magnitudes with a
// sign fix-up. The start edge already retires the first bit, so done is high
// exactly DIV_W cycles after the cycle in which start was asserted.
module serial_sdiv #(
    parameter int DIV_W = 64
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic signed [DIV_W-1:0] dividend,
    input  logic signed [DIV_W-1:0] divisor,
    output logic                    busy,
    output logic                    done,
    output logic signed [31:0]      quotient,
    output logic                    ovf
);
    localparam int CW = $clog2(DIV_W);
    localparam logic [DIV_W-1:0] LIM_POS = DIV_W'(32'h7FFF_FFFF);
    localparam logic [DIV_W-1:0] LIM_NEG = DIV_W'(32'h8000_0000);

    logic [DIV_W:0]   rem;
    logic [DIV_W-1:0] qr;
    logic [DIV_W-1:0] dvs_mag;
    logic [DIV_W-1:0] dvd_in_mag, dvs_in_mag;
    logic             neg;
    logic [CW-1:0]    cnt;

    // One shift-subtract step: returns {remainder, quotient/dividend shifter}.
    function automatic logic [2*DIV_W:0] div_step(input logic [DIV_W:0]   r,
                                                  input logic [DIV_W-1:0] q,
                                                  input logic [DIV_W-1:0] d);
        logic [DIV_W+1:0] sh, df;
        sh = {r, q[DIV_W-1]};
        df = sh - {2'b00, d};
        if (df[DIV_W+1])
            return {sh[DIV_W:0], q[DIV_W-2:0], 1'b0};
        else
            return {df[DIV_W:0], q[DIV_W-2:0], 1'b1};
    endfunction

    assign dvd_in_mag = dividend[DIV_W-1] ? DIV_W'(-dividend) : DIV_W'(dividend);
    assign dvs_in_mag = divisor[DIV_W-1]  ? DIV_W'(-divisor)  : DIV_W'(divisor);

    // Iterate the quotient bits; done pulses for one cycle after the last bit.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rem     <= '0;
            qr      <= '0;
            dvs_mag <= '0;
            neg     <= 1'b0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                {rem, qr} <= div_step('0, dvd_in_mag, dvs_in_mag);
                dvs_mag   <= dvs_in_mag;
                neg       <= dividend[DIV_W-1] ^ divisor[DIV_W-1];
                cnt       <= CW'(DIV_W - 1);
                busy      <= 1'b1;
            end else if (busy) begin
                {rem, qr} <= div_step(rem, qr, dvs_mag);
                cnt       <= cnt - 1'b1;
                if (cnt == CW'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    assign quotient = neg ? 32'(~qr + 1'b1) : qr[31:0];
    assign ovf      = neg ? (qr > LIM_NEG) : (qr > LIM_POS);

endmodule

// File: rtl/plane_setup_seq.sv
// Plane-equation setup: one shared multiplier, one serial divider, and an FSM
// that walks cross products -> differences -> two divides -> constant term.
module plane_setup_seq
    import pvr_plane_pkg::*;
#(
    parameter int DIV_W = 64
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [7:0]         frac_bits,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic signed [31:0] fx1, fx2, fx3,
    input  logic signed [31:0] fy1, fy2, fy3,
    input  logic signed [31:0] fz1, fz2, fz3,
    output logic               out_valid,
    input  logic               out_ready,
    output logic signed [31:0] ddx,
    output logic signed [31:0] ddy,
    output logic signed [31:0] c,
    output logic               degenerate,
    output logic               ovf
);
    state_t                   state, state_nxt;
    logic [2:0]               cnt;
    logic [7:0]               f_r;
    logic signed [31:0]       x1_r, x2_r, x3_r, y1_r, y2_r, y3_r, z1_r, z2_r, z3_r;
    logic signed [31:0]       dx21, dx31, dy21, dy31, dz21, dz31;
    logic signed [31:0]       mul_a, mul_b;
    logic signed [PROD_W-1:0] prod_full, prod, mul_q;
    logic signed [PROD_W-1:0] p_r [0:MUL_STEPS-2];
    logic signed [SUB_W-1:0]  aa_sub, ba_sub, c_sub, ba_r, cc_r;
    logic signed [31:0]       dx_r, dy_r, t1_r;
    logic                     degen_r, ovf_r;
    logic                     div_start, div_busy, div_done, div_ovf;
    logic signed [DIV_W-1:0]  div_dvd, div_dvs;
    logic signed [31:0]       div_q;
    logic                     accept;

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_OUT);
    assign accept    = in_valid && (state == ST_IDLE);

    assign dx21 = x2_r - x1_r;
    assign dx31 = x3_r - x1_r;
    assign dy21 = y2_r - y1_r;
    assign dy31 = y3_r - y1_r;
    assign dz21 = z2_r - z1_r;
    assign dz31 = z3_r - z1_r;

    // Operand select for the shared multiplier.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        if (state == ST_MUL) begin
            case (cnt)
                3'd0:    begin mul_a = dz31; mul_b = dy21; end
                3'd1:    begin mul_a = dz21; mul_b = dy31; end
                3'd2:    begin mul_a = dx31; mul_b = dz21; end
                3'd3:    begin mul_a = dx21; mul_b = dz31; end
                3'd4:    begin mul_a = dx21; mul_b = dy31; end
                default: begin mul_a = dx31; mul_b = dy21; end
            endcase
        end else if (state == ST_CONST) begin
            if (cnt == 3'd0) begin mul_a = dx_r; mul_b = x1_r; end
            else             begin mul_a = dy_r; mul_b = y1_r; end
        end
    end

    assign prod_full = PROD_W'(mul_a) * PROD_W'(mul_b);
    assign prod      = prod_full >>> f_r;

    // The last cross product is still in mul_q during SUB.
    assign aa_sub = SUB_W'(p_r[0] - p_r[1]);
    assign ba_sub = SUB_W'(p_r[2] - p_r[3]);
    assign c_sub  = SUB_W'(mul_q - p_r[4]);

    // Divider operands: X starts straight out of SUB, Y from the saved values.
    always_comb begin
        if (state == ST_SUB) begin
            div_dvd = DIV_W'(aa_sub) <<< f_r;
            div_dvs = DIV_W'(c_sub);
        end else begin
            div_dvd = DIV_W'(ba_r) <<< f_r;
            div_dvs = DIV_W'(cc_r);
        end
    end

    // Next-state decode and divider launch.
    always_comb begin
        state_nxt = state;
        div_start = 1'b0;
        unique case (state)
            ST_IDLE:  if (in_valid) state_nxt = ST_MUL;
            ST_MUL:   if (cnt == 3'(MUL_STEPS - 1)) state_nxt = ST_SUB;
            ST_SUB:
                if (c_sub == '0) state_nxt = ST_CONST;
                else begin
                    div_start = 1'b1;
                    state_nxt = ST_DIV_X;
                end
            ST_DIV_X:
                if (div_done && !div_busy) begin
                    div_start = 1'b1;
                    state_nxt = ST_DIV_Y;
                end
            ST_DIV_Y: if (div_done && !div_busy) state_nxt = ST_CONST;
            ST_CONST: if (cnt == 3'(CONST_STEPS - 1)) state_nxt = ST_OUT;
            ST_OUT:   if (out_ready) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // State register; cnt restarts on every state change.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= (state_nxt != state) ? 3'd0 : cnt + 3'd1;
        end
    end

    // Datapath: input latch, product capture, differences, quotients.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            f_r   <= '0;
            x1_r  <= '0; x2_r <= '0; x3_r <= '0;
            y1_r  <= '0; y2_r <= '0; y3_r <= '0;
            z1_r  <= '0; z2_r <= '0; z3_r <= '0;
            mul_q <= '0;
            for (int i = 0; i < MUL_STEPS - 1; i++) p_r[i] <= '0;
            ba_r    <= '0;
            cc_r    <= '0;
            dx_r    <= '0;
            dy_r    <= '0;
            t1_r    <= '0;
            degen_r <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            mul_q <= prod;
            if (accept) begin
                f_r  <= (frac_bits > 8'(MAX_FRAC)) ? 8'(MAX_FRAC) : frac_bits;
                x1_r <= fx1; x2_r <= fx2; x3_r <= fx3;
                y1_r <= fy1; y2_r <= fy2; y3_r <= fy3;
                z1_r <= fz1; z2_r <= fz2; z3_r <= fz3;
            end
            if (state == ST_MUL && cnt != 3'd0) p_r[cnt - 3'd1] <= mul_q;
            if (state == ST_SUB) begin
                ba_r    <= ba_sub;
                cc_r    <= c_sub;
                degen_r <= (c_sub == '0);
                if (c_sub == '0) begin
                    dx_r  <= '0;
                    dy_r  <= '0;
                    ovf_r <= 1'b0;
                end
            end
            if (state == ST_DIV_X && div_done) begin
                dx_r  <= div_q;
                ovf_r <= div_ovf;
            end
            if (state == ST_DIV_Y && div_done) begin
                dy_r  <= div_q;
                ovf_r <= ovf_r | div_ovf;
            end
            if (state == ST_CONST && cnt == 3'd1) t1_r <= mul_q[31:0];
        end
    end

    // Visible results update only on entry to OUT.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ddx        <= '0;
            ddy        <= '0;
            c          <= '0;
            degenerate <= 1'b0;
            ovf        <= 1'b0;
        end else if (state == ST_CONST && state_nxt == ST_OUT) begin
            ddx        <= dx_r;
            ddy        <= dy_r;
            c          <= z1_r - t1_r - mul_q[31:0];
            degenerate <= degen_r;
            ovf        <= ovf_r;
        end
    end

    serial_sdiv #(.DIV_W(DIV_W)) u_div (
        .clock    (clock),
        .reset_n  (reset_n),
        .start    (div_start),
        .dividend (div_dvd),
        .divisor  (div_dvs),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_q),
        .ovf      (div_ovf)
    );

endmodule

// File: tb/tb_plane_setup_seq.sv
// Directed bench for plane_setup_seq with hand-computed coefficients.
module tb_plane_setup_seq;
    logic               clock = 1'b0;
    logic               reset_n = 1'b0;
    logic [7:0]         frac_bits = '0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [31:0] fx1 = '0, fx2 = '0, fx3 = '0;
    logic signed [31:0] fy1 = '0, fy2 = '0, fy3 = '0;
    logic signed [31:0] fz1 = '0, fz2 = '0, fz3 = '0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic signed [31:0] ddx, ddy, c;
    logic               degenerate, ovf;

    int n_chk  = 0;
    int n_pass = 0;
    int lat;

    plane_setup_seq #(.DIV_W(64)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .frac_bits  (frac_bits),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .fx1        (fx1), .fx2(fx2), .fx3(fx3),
        .fy1        (fy1), .fy2(fy2), .fy3(fy3),
        .fz1        (fz1), .fz2(fz2), .fz3(fz3),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ddx        (ddx),
        .ddy        (ddy),
        .c          (c),
        .degenerate (degenerate),
        .ovf        (ovf)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)", tag, got, got, exp, exp);
    endtask

    task automatic set_vec(input logic [7:0] f,
                           input logic signed [31:0] a1, a2, a3,
                           input logic signed [31:0] b1, b2, b3,
                           input logic signed [31:0] d1, d2, d3);
        frac_bits = f;
        fx1 = a1; fx2 = a2; fx3 = a3;
        fy1 = b1; fy2 = b2; fy3 = b3;
        fz1 = d1; fz2 = d2; fz3 = d3;
    endtask

    // Accept one vertex set and count posedges until out_valid (bounded).
    task automatic run(output int n);
        in_valid = 1'b1;
        @(posedge clock);
        #1 in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 400) begin
            @(posedge clock);
            #1;
            n++;
        end
    endtask

    task automatic chk_out(input string t, input logic [31:0] edx, edy, ec,
                           input logic edeg, eovf);
        chk({t, " ddx"}, ddx, edx);
        chk({t, " ddy"}, ddy, edy);
        chk({t, " c"}, c, ec);
        chk({t, " degenerate"}, {31'd0, degenerate}, {31'd0, edeg});
        chk({t, " ovf"}, {31'd0, ovf}, {31'd0, eovf});
    endtask

    task automatic handshake(input string t);
        out_ready = 1'b1;
        @(posedge clock);
        #1 out_ready = 1'b0;
        chk({t, " out_valid after hs"}, {31'd0, out_valid}, 32'd0);
        chk({t, " in_ready after hs"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst in_ready", {31'd0, in_ready}, 32'd1);
        chk_out("rst", 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        @(posedge clock);
        #1 reset_n = 1'b1;

        // T1: basic right triangle
        set_vec(8'd16, 0, 655360, 0, 0, 0, 655360, 0, 655360, 1310720);
        run(lat);
        chk("t1 latency", lat, 32'd138);
        chk_out("t1", 32'd65536, 32'd131072, 32'd0, 1'b0, 1'b0);
        handshake("t1");

        // T2: shifted x with z offset; out_ready held high beforehand
        set_vec(8'd16, 131072, 786432, 131072, 0, 0, 655360, 327680, 983040, 1638400);
        out_ready = 1'b1;
        run(lat);
        chk("t2 latency", lat, 32'd138);
        chk_out("t2", 32'd65536, 32'd131072, 32'd196608, 1'b0, 1'b0);
        @(posedge clock);
        #1;
        chk("t2 out_valid after hs", {31'd0, out_valid}, 32'd0);
        chk("t2 in_ready after hs", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b0;

        // T3: collinear vertices
        set_vec(8'd16, 0, 65536, 131072, 0, 65536, 131072, 458752, 0, 0);
        run(lat);
        chk("t3 latency", lat, 32'd10);
        chk_out("t3", 32'd0, 32'd0, 32'd458752, 1'b1, 1'b0);
        handshake("t3");

        // T4: back-pressure; in_valid with junk while not idle is ignored
        set_vec(8'd16, 0, 655360, 0, 0, 0, 655360, 0, 655360, 1310720);
        run(lat);
        set_vec(8'd0, 123, 456, 789, 1, 2, 3, 4, 5, 6);
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock);
            #1;
            chk("t4 out_valid held", {31'd0, out_valid}, 32'd1);
            chk("t4 in_ready low", {31'd0, in_ready}, 32'd0);
            chk("t4 ddx stable", ddx, 32'd65536);
        end
        in_valid = 1'b0;
        chk_out("t4", 32'd65536, 32'd131072, 32'd0, 1'b0, 1'b0);
        handshake("t4");

        // T5: reset mid-DIV_Y aborts, then a clean rerun
        set_vec(8'd16, 0, 655360, 0, 0, 0, 655360, 0, 655360, 1310720);
        in_valid = 1'b1;
        @(posedge clock);
        #1 in_valid = 1'b0;
        repeat (100) @(posedge clock);
        #1 reset_n = 1'b0;
        #1;
        chk("t5 rst out_valid", {31'd0, out_valid}, 32'd0);
        chk("t5 rst in_ready", {31'd0, in_ready}, 32'd1);
        chk("t5 rst ddx", ddx, 32'd0);
        chk("t5 rst ddy", ddy, 32'd0);
        chk("t5 rst c", c, 32'd0);
        @(posedge clock);
        #1 reset_n = 1'b1;
        run(lat);
        chk("t5 latency", lat, 32'd138);
        chk_out("t5", 32'd65536, 32'd131072, 32'd0, 1'b0, 1'b0);
        handshake("t5");

        // T6: C = -1, quotient 2^36 + 3*2^16 overflows; low word is 196608
        set_vec(8'd16, 0, 1, 0, 0, 0, 65536, 0, 1048579, 0);
        run(lat);
        chk("t6 latency", lat, 32'd138);
        chk_out("t6", 32'd196608, 32'd0, 32'd0, 1'b0, 1'b1);
        handshake("t6");

        // T7: f=0, negative quotient truncates toward zero (14/-6 = -2, -15/-6 = 2)
        set_vec(8'd0, 1, 4, 1, 0, 0, 2, 0, -7, 5);
        run(lat);
        chk("t7 latency", lat, 32'd138);
        chk_out("t7", 32'hFFFF_FFFE, 32'd2, 32'd2, 1'b0, 1'b0);
        handshake("t7");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
